// File: rtl/seq_left_shifter_pkg.sv
// Shared definitions for the sequential left shifter: default widths and FSM state encoding.
package seq_left_shifter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SW    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift32_l1_step.sv
// One-bit left step of a 32-bit word; bit 0 is zero-filled or takes the old bit 31.
module shift32_l1_step
  import seq_left_shifter_pkg::*;
(
  input  logic [DEF_WIDTH-1:0] word,
  input  logic                 ROT,
  output logic [DEF_WIDTH-1:0] next_word
);

  assign next_word = {word[DEF_WIDTH-2:0], ROT & word[DEF_WIDTH-1]};

endmodule

// File: rtl/seq_left_shifter.sv
// Multi-cycle left shifter/rotator: one bit per clock, result registered on Y with a DONE pulse.
module seq_left_shifter
  import seq_left_shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SW    = DEF_SW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ROT,
  input  logic [WIDTH-1:0] D,
  input  logic [SW-1:0]    S,
  output logic [WIDTH-1:0] Y,
  output logic             BUSY,
  output logic             DONE
);

  state_t           state;
  logic [SW-1:0]    count;
  logic [WIDTH-1:0] work;
  logic             rot_q;
  logic [WIDTH-1:0] step_word;

  shift32_l1_step u_step (
    .word      (work),
    .ROT       (rot_q),
    .next_word (step_word)
  );

  // NOTE: all state here updates with non-blocking assignments so every register sees
  // the pre-edge values of the others; the async reset clears every register, including Y.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      count <= '0;
      work  <= '0;
      rot_q <= 1'b0;
      Y     <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            work  <= D;
            rot_q <= ROT;
            BUSY  <= 1'b1;
            if (S == '0) begin
              Y     <= D;
              DONE  <= 1'b1;
              state <= ST_DONE;
            end else begin
              count <= S;
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work  <= step_word;
          count <= count - 1'b1;
          if (count == SW'(1)) begin
            Y     <= step_word;
            DONE  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // START is deliberately not looked at here: requests during DONE are dropped.
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_left_shifter.sv
// Directed self-checking bench for seq_left_shifter: shift/rotate results, latency, ignored starts, reset.
module tb_seq_left_shifter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        ROT;
  logic [31:0] D;
  logic [4:0]  S;
  logic [31:0] Y;
  logic        BUSY;
  logic        DONE;

  int n_checks = 0;
  int n_errors = 0;

  seq_left_shifter dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .ROT   (ROT),
    .D     (D),
    .S     (S),
    .Y     (Y),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one operation and waits for DONE; optionally pulses a second START mid-flight
  // and during the DONE cycle. Inputs are scrambled right after the start edge.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic rot,
                        input bit interfere,
                        output logic [31:0] y, output int lat, output bit busy_all,
                        output int extra_dones);
    int cycles;
    cycles      = 0;
    busy_all    = 1'b1;
    extra_dones = 0;
    @(negedge CLK);
    D = d; S = s; ROT = rot; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    D = $urandom; S = 5'($urandom); ROT = ~rot;
    while (!DONE && cycles < 40) begin
      busy_all &= BUSY;
      if (interfere && cycles == 10) begin
        START = 1'b1; D = 32'h7811bf90; S = 5'd3; ROT = 1'b0;
      end
      @(posedge CLK);
      #1;
      START = 1'b0;
      cycles++;
    end
    busy_all &= BUSY;
    lat = DONE ? cycles + 1 : -1;
    y   = Y;
    if (interfere) START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (DONE) extra_dones++;
      @(posedge CLK);
      #1;
    end
  endtask

  logic [31:0] y;
  int          lat;
  bit          busy_all;
  int          extra;

  initial begin
    RST = 1'b1; START = 1'b0; ROT = 1'b0; D = '0; S = '0;
    #12;
    check("reset_y", Y, 32'h0);
    check("reset_busy", 32'(BUSY), 32'h0);
    check("reset_done", 32'(DONE), 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Idle with START low: Y must not follow D.
    D = 32'hdeadbeef;
    repeat (3) @(posedge CLK);
    #1;
    check("idle_y_hold", Y, 32'h0);
    check("idle_busy", 32'(BUSY), 32'h0);

    run_op(32'h00000001, 5'd1, 1'b0, 1'b0, y, lat, busy_all, extra);
    check("s1_y", y, 32'h00000002);
    check("s1_latency", 32'(lat), 32'd2);
    check("s1_extra_done", 32'(extra), 32'd0);

    run_op(32'hffffffff, 5'd5, 1'b0, 1'b0, y, lat, busy_all, extra);
    check("s5_y", y, 32'hffffffe0);
    check("s5_latency", 32'(lat), 32'd6);
    check("s5_busy_all", 32'(busy_all), 32'd1);

    run_op(32'h198af7b1, 5'd31, 1'b1, 1'b0, y, lat, busy_all, extra);
    check("rot31_y", y, 32'h8cc57bd8);
    check("rot31_latency", 32'(lat), 32'd32);

    run_op(32'h9078af1b, 5'd20, 1'b0, 1'b1, y, lat, busy_all, extra);
    check("s20_y", y, 32'hf1b00000);
    check("s20_latency", 32'(lat), 32'd21);
    check("s20_ignored_starts", 32'(extra), 32'd0);
    check("s20_y_after", Y, 32'hf1b00000);
    check("s20_idle_busy", 32'(BUSY), 32'h0);

    run_op(32'hffffffff, 5'd0, 1'b0, 1'b0, y, lat, busy_all, extra);
    check("s0_y", y, 32'hffffffff);
    check("s0_latency", 32'(lat), 32'd1);
    check("s0_busy", 32'(busy_all), 32'd1);

    // Async reset in the middle of a long shift.
    @(negedge CLK);
    D = 32'h00000001; S = 5'd31; ROT = 1'b0; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #3;
    check("pre_rst_busy", 32'(BUSY), 32'h1);
    RST = 1'b1;
    #1;
    check("rst_y", Y, 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_done", 32'(DONE), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) extra++;
    end
    check("rst_no_done", 32'(extra), 32'd0);
    check("rst_y_hold", Y, 32'h0);

    // START honoured on the first edge after reset release.
    @(negedge CLK);
    RST = 1'b1;
    #1;
    RST = 1'b0;
    D = 32'h80000001; S = 5'd1; ROT = 1'b1; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check("post_rst_busy", 32'(BUSY), 32'h1);
    @(posedge CLK);
    #1;
    check("post_rst_done", 32'(DONE), 32'h1);
    check("post_rst_y", Y, 32'h00000003);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_left_shifter.md
SEQ_LEFT_SHIFTER -- requirements
Module: seq_left_shifter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, data word width; only 32 is supported.
REQ-002 The module SHALL have parameter SW, default 5, shift-amount width (log2 WIDTH).
REQ-003 The module SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port START, input, 1, request to begin an operation, sampled only in IDLE.
REQ-006 The module SHALL have port ROT, input, 1, mode select: 0 = logical left shift (zero fill), 1 = rotate left.
REQ-007 The module SHALL have port D, input, WIDTH, operand.
REQ-008 The module SHALL have port S, input, SW, shift amount, 0..31.
REQ-009 The module SHALL have port Y, output, WIDTH, registered result.
REQ-010 The module SHALL have port BUSY, output, 1, high whenever state is not IDLE.
REQ-011 The module SHALL have port DONE, output, 1, one-cycle result-valid pulse.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE, on a rising edge k with START=1, the module SHALL capture D, S and ROT into internal registers.
REQ-014 At that edge k, the FSM SHALL go to DONE if S=0, else to SHIFT with count=S.
REQ-015 In IDLE with START=0, the FSM SHALL stay in IDLE and leave Y unchanged.
REQ-016 In SHIFT, each edge SHALL shift the working register left by one bit and decrement count.
REQ-017 In each SHIFT step, bit 0 SHALL receive 0 when ROT=0, or the previous bit 31 when ROT=1.
REQ-018 In SHIFT, the edge at which count=1 SHALL perform the final step and move the FSM to DONE.
REQ-019 Y SHALL load the final working value on the edge entering DONE and hold it until the next DONE entry or reset.
REQ-020 DONE SHALL be high for exactly the one cycle following edge k+S (S=0: the cycle following edge k).
REQ-021 From DONE, the FSM SHALL return to IDLE unconditionally on the next edge.
REQ-022 START while BUSY=1, including the DONE cycle, SHALL be ignored; no queuing.
REQ-023 Changes of D, S or ROT after edge k SHALL NOT affect the operation in flight.
REQ-024 The result SHALL equal D<<S (truncated to WIDTH) for ROT=0, and rotate-left(D,S) for ROT=1.
REQ-025 Total latency SHALL be S+1 edges from the START-sampling edge to the first edge at which DONE is observed high; maximum 32.

Reset
REQ-026 RST=1 SHALL immediately, independent of CLK, force state=IDLE, Y=0, BUSY=0, DONE=0, count=0, and clear the working register.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no DONE pulse and no Y update.
REQ-028 After RST deasserts, the module SHALL accept START on the first rising edge.

Structure
REQ-029 The state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default WIDTH/SW constants SHALL be defined in the shared project definitions include, not locally.
REQ-030 The one-bit shift/rotate step SHALL be a separate combinational sub-module shift32_l1_step (inputs: word, ROT; output: next word), instantiated once.

Verification
REQ-031 The bench SHALL apply D=0x00000001, S=1, ROT=0, START for one cycle -> DONE observed at the 2nd edge after the start edge, Y=0x00000002.
REQ-032 The bench SHALL apply D=0xffffffff, S=5, ROT=0 -> Y=0xffffffe0 after 6 edges; BUSY high throughout.
REQ-033 The bench SHALL apply D=0x198af7b1, S=31, ROT=1 -> Y=0x8cc57bd8, with DONE at latency 32.
REQ-034 The bench SHALL apply D=0x9078af1b, S=20, ROT=0 -> Y=0xf1b00000; a second START pulsed mid-operation with D=0x7811bf90 is ignored and produces only one DONE.
REQ-035 The bench SHALL apply D=0xffffffff, S=0 -> DONE in the cycle after the start edge, Y=0xffffffff.
REQ-036 The bench SHALL start D=0x00000001, S=31, then assert RST asynchronously mid-cycle after 10 edges -> Y=0, BUSY=0, DONE=0 immediately; no DONE follows.
